// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder
//  Purpose  : WIDTH-bit add/subtract split into STAGES carry-linked segments,
//             with valid/ready handshake and carry/overflow flags.
//  Revision : 1.0
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SEG = WIDTH / STAGES;

  logic             w_advance;
  logic [WIDTH-1:0] w_bx;

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;
  assign w_bx      = b ^ {WIDTH{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added on entry to this stage, including its own segment
    localparam int REM = WIDTH - k*SEG;

    logic               w_vld;
    logic               w_cin;
    logic [REM-1:0]     w_a;
    logic [REM-1:0]     w_b;
    logic [SEG:0]       w_sum;
    logic               r_vld;
    logic               r_cy;
    logic [(k+1)*SEG-1:0] r_res;

    assign w_sum = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_cin};

    if (k == 0) begin : g_in
      assign w_vld = in_valid;
      assign w_cin = sub;
      assign w_a   = a;
      assign w_b   = w_bx;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_res <= '0;
        else if (w_advance) r_res <= w_sum[SEG-1:0];
      end
    end else begin : g_in
      assign w_vld = g_stage[k-1].r_vld;
      assign w_cin = g_stage[k-1].r_cy;
      assign w_a   = g_stage[k-1].g_rem.r_opa;
      assign w_b   = g_stage[k-1].g_rem.r_opb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_res <= '0;
        else if (w_advance) r_res <= {w_sum[SEG-1:0], g_stage[k-1].r_res};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
      end else if (w_advance) begin
        r_vld <= w_vld;
        r_cy  <= w_sum[SEG];
      end
    end

    if (k < STAGES-1) begin : g_rem
      logic [REM-SEG-1:0] r_opa;
      logic [REM-SEG-1:0] r_opb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_opa <= '0;
          r_opb <= '0;
        end else if (w_advance) begin
          r_opa <= w_a[REM-1:SEG];
          r_opb <= w_b[REM-1:SEG];
        end
      end
    end else begin : g_last
      // The top segment sees the operand sign bits directly, so overflow is resolved here
      logic w_ovf;
      logic r_ovf;

      assign w_ovf = (w_a[REM-1] == w_b[REM-1]) && (w_sum[SEG-1] != w_a[REM-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_ovf <= 1'b0;
        else if (w_advance) r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign result    = g_stage[STAGES-1].r_res;
  assign carry_out = g_stage[STAGES-1].r_cy;
  assign overflow  = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder
//  Purpose  : Directed vectors for pipelined_adder at STAGES = 2, 1 and 4.
//  Revision : 1.0
// ============================================================================
module tb_pipelined_adder;

  localparam int W  = 32;
  localparam int NV = 12;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_ready;
  int           cur;

  logic [2:0]   iv;
  logic [2:0]   orr;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [2:0]   cy;
  logic [2:0]   of;
  logic [W-1:0] res [3];

  logic         m_ir;
  logic         m_ov;
  logic         m_cy;
  logic         m_of;
  logic [W-1:0] m_res;

  int   checks = 0;
  int   errors = 0;
  int   stg [3] = '{2, 1, 4};
  vec_t vt [NV];

  always #5 clk = ~clk;

  // Only the selected instance sees traffic; the others stay idle and drained
  for (genvar i = 0; i < 3; i++) begin : g_sel
    assign iv[i]  = in_valid && (cur == i);
    assign orr[i] = (cur == i) ? out_ready : 1'b1;
  end

  assign m_ir  = ir[cur];
  assign m_ov  = ov[cur];
  assign m_cy  = cy[cur];
  assign m_of  = of[cur];
  assign m_res = res[cur];

  pipelined_adder #(.WIDTH(W), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[0]), .out_ready(orr[0]), .result(res[0]), .carry_out(cy[0]), .overflow(of[0]));

  pipelined_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[1]), .out_ready(orr[1]), .result(res[1]), .carry_out(cy[1]), .overflow(of[1]));

  pipelined_adder #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[2]), .out_ready(orr[2]), .result(res[2]), .carry_out(cy[2]), .overflow(of[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (stages=%0d): got %h expected %h", name, stg[cur], act, exp);
    end
  endtask

  // Back-to-back vectors; each result must appear exactly STAGES cycles after its accept
  task automatic run_table();
    int s;
    s = stg[cur];
    out_ready = 1'b1;
    for (int t = 0; t < NV + s; t++) begin
      @(negedge clk);
      if (t >= s)
        check("tbl_vec", {29'd0, m_ov, m_cy, m_of, m_res},
              {29'd0, 1'b1, vt[t-s].c, vt[t-s].o, vt[t-s].r});
      else
        check("tbl_latency", {63'd0, m_ov}, 64'd0);
      if (t < NV) begin
        in_valid = 1'b1;
        a        = vt[t].a;
        b        = vt[t].b;
        sub      = vt[t].sub;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  // Stream 1..8 as a+0 under random out_ready
  task automatic run_stream();
    int           nin;
    int           nout;
    logic         pv;
    logic         pr;
    logic [W-1:0] pres;
    nin  = 1;
    nout = 1;
    pv   = 1'b0;
    pr   = 1'b1;
    pres = '0;
    sub  = 1'b0;
    b    = '0;
    for (int cyc = 0; cyc < 300 && nout <= 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (nin <= 8);
      a         = W'(nin);
      #1;
      if (pv && !pr)
        check("stall_hold", {31'd0, m_ov, m_res}, {31'd0, 1'b1, pres});
      if (m_ov && !out_ready)
        check("stall_in_ready", {63'd0, m_ir}, 64'd0);
      if (m_ov && out_ready) begin
        check("stream_data", {32'd0, m_res}, 64'(nout));
        nout++;
      end
      if (in_valid && m_ir) nin++;
      pv   = m_ov;
      pr   = out_ready;
      pres = m_res;
    end
    check("stream_count", 64'(nout - 1), 64'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    cur       = 0;

    vt[0]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vt[1]  = '{32'h00000005, 32'h0000000A, 1'b0, 32'h0000000F, 1'b0, 1'b0};
    vt[2]  = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 1'b1, 1'b0};
    vt[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[4]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vt[5]  = '{32'h0000000A, 32'h00000005, 1'b1, 32'h00000005, 1'b1, 1'b0};
    vt[6]  = '{32'h00000005, 32'h0000000A, 1'b1, 32'hFFFFFFFB, 1'b0, 1'b0};
    vt[7]  = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[9]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vt[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
    vt[11] = '{32'h12345678, 32'hEDCBA988, 1'b0, 32'h00000000, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    check("reset_valid_all", {61'd0, ov}, 64'd0);
    check("reset_outputs", {30'd0, m_ir, m_cy, m_of, m_res}, {30'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3; c++) begin
      cur = c;
      run_table();
      run_stream();
    end

    // Reset with two results in flight on the two-stage instance
    cur       = 0;
    out_ready = 1'b1;
    sub       = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; a = 32'd1; b = 32'd1;
    @(negedge clk);
    a = 32'd2; b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_reset_result", {31'd0, m_ov, m_res}, {31'd0, 1'b1, 32'd2});
    rst_n = 1'b0;
    #1;
    check("async_reset_out", {31'd0, m_ov, m_res}, 64'd0);
    check("async_reset_in_ready", {63'd0, m_ir}, 64'd1);
    @(negedge clk);
    check("reset_held", {31'd0, m_ov, m_res}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!m_ov && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("post_reset_valid", {63'd0, m_ov}, 64'd1);
    check("post_reset_result", {32'd0, m_res}, 64'd7);
    check("post_reset_latency", 64'(lat), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
